// File: rtl/reg_port_arbiter_pkg.sv
// Shared types and default sizing for the register-port arbiter.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int DEF_ADDR_W  = 3;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 15;

    // Width of a counter that must reach t-1; never narrower than one bit.
    function automatic int wait_w(input int t);
        return (t < 2) ? 1 : $clog2(t);
    endfunction

    localparam int WAIT_W = wait_w(DEF_TIMEOUT);

endpackage

// File: rtl/reg_port_arbiter_if.sv
// Single register-access port of the dut: one write channel, one read channel,
// each enabled by the arbiter and qualified by the dut's rdy.
interface reg_port_arbiter_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_data;
    logic              write_en;
    logic              write_rdy;
    logic [ADDR_W-1:0] read_address;
    logic              read_en;
    logic [DATA_W-1:0] read_data;
    logic              read_rdy;

    // Arbiter side: drives addresses, data and enables.
    modport master (
        output write_address, write_data, write_en, read_address, read_en,
        input  write_rdy, read_data, read_rdy
    );

    // Dut side.
    modport slave (
        input  write_address, write_data, write_en, read_address, read_en,
        output write_rdy, read_data, read_rdy
    );
endinterface

// File: rtl/reg_port_arbiter_rr_arb2.sv
// Two-way round-robin grant: ptr names the requester with priority this cycle.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       any
);
    // Prefer the pointed-to requester, fall back to the other one.
    always_comb begin
        gnt = 2'b00;
        if (req[ptr]) begin
            gnt[ptr] = 1'b1;
        end else if (req[~ptr]) begin
            gnt[~ptr] = 1'b1;
        end
        any = |req;
    end
endmodule

// File: rtl/reg_port_arbiter.sv
// Shares the dut register port between two requesters, one transaction at a time.
//
// Handshakes: a command is taken when cmd_ready[i] pulses while cmd_valid[i] is
// high (cmd_ready is only ever raised for a valid requester, in IDLE); a
// response is retired when rsp_valid[i] and rsp_ready[i] are both high; a dut
// transfer happens in the cycle write_en/read_en is high, which is only ever
// raised while the matching rdy is high.
module reg_port_arbiter
    import reg_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [1:0]          cmd_valid,
    output logic [1:0]          cmd_ready,
    input  logic [1:0]          cmd_we,
    input  logic [2*ADDR_W-1:0] cmd_addr,
    input  logic [2*DATA_W-1:0] cmd_wdata,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    reg_port_arbiter_if.master  bus,
    output logic                busy,
    output logic [7:0]          txn_cnt,
    output logic [7:0]          err_cnt,
    output state_t              dbg_state,
    output logic                dbg_rr_ptr
);
    localparam int WW = wait_w(TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              rr_ptr_q;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [WW-1:0]     wait_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [7:0]        txn_cnt_q;
    logic [7:0]        err_cnt_q;

    logic [1:0] gnt;
    logic       any_req;
    logic       win_idx;
    logic       fire;
    logic       timeout;

    rr_arb2 u_arb (
        .req (cmd_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .any (any_req)
    );

    assign win_idx = gnt[1];

    // Dut-side drive: addresses/data always from the latches, enables gated by rdy.
    always_comb begin
        bus.write_address = addr_q;
        bus.read_address  = addr_q;
        bus.write_data    = wdata_q;
        bus.write_en      = (state_q == ISSUE) &&  we_q && bus.write_rdy;
        bus.read_en       = (state_q == ISSUE) && !we_q && bus.read_rdy;
        fire              = bus.write_en || bus.read_en;
        timeout           = (state_q == ISSUE) && !fire && (wait_q == WAIT_LAST);
    end

    // Requester-side outputs and status.
    always_comb begin
        cmd_ready  = (state_q == IDLE) ? gnt : 2'b00;
        rsp_valid  = 2'b00;
        if (state_q == RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
        rsp_rdata  = rdata_q;
        rsp_err    = err_q;
        busy       = (state_q != IDLE);
        txn_cnt    = txn_cnt_q;
        err_cnt    = err_cnt_q;
        dbg_state  = state_q;
        dbg_rr_ptr = rr_ptr_q;
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req)             state_d = ISSUE;
            ISSUE:   if (fire || timeout)     state_d = RESP;
            RESP:    if (rsp_ready[owner_q])  state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Command latch, wait counter, response capture and statistics.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rr_ptr_q  <= 1'b0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wait_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            txn_cnt_q <= 8'd0;
            err_cnt_q <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q  <= win_idx;
                        rr_ptr_q <= ~win_idx;
                        we_q     <= cmd_we[win_idx];
                        addr_q   <= win_idx ? cmd_addr[ADDR_W +: ADDR_W]
                                            : cmd_addr[0 +: ADDR_W];
                        wdata_q  <= win_idx ? cmd_wdata[DATA_W +: DATA_W]
                                            : cmd_wdata[0 +: DATA_W];
                        wait_q   <= '0;
                    end
                end
                ISSUE: begin
                    if (fire) begin
                        rdata_q   <= we_q ? '0 : bus.read_data;
                        err_q     <= 1'b0;
                        txn_cnt_q <= txn_cnt_q + 8'd1;
                    end else if (timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
